// File: rtl/mem_copy_engine_if.sv
// ----------------------------------------------------------------------------
// mem_copy_engine_if
// Single-port external memory bus as seen by a processor-style initiator.
//   memread   : initiator -> memory, high during a read cycle
//   memwrite  : initiator -> memory, high during a write cycle; the memory
//               commits writedata at adr on the next rising clock edge
//   adr       : initiator -> memory, byte address
//   writedata : initiator -> memory, write data
//   memdata   : memory -> initiator, combinational read data for adr
// Modports: master (the copy engine), slave (the memory).
// ----------------------------------------------------------------------------
interface mem_copy_engine_if #(
  parameter int WIDTH = 32
);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;

  modport master (
    output memread,
    output memwrite,
    output adr,
    output writedata,
    input  memdata
  );

  modport slave (
    input  memread,
    input  memwrite,
    input  adr,
    input  writedata,
    output memdata
  );
endinterface

// File: rtl/mem_copy_engine.sv
// ----------------------------------------------------------------------------
// mem_copy_engine
// DMA-style helper that copies len 32-bit words from src_adr to dst_adr over
// the single-port memory bus: one READ cycle (combinational memdata captured
// at the closing edge) followed by one WRITE cycle per word.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : copy request, sampled only while idle
//   src_adr, dst_adr    : word-aligned byte addresses
//   len                 : word count (0 allowed)
//   busy                : high whenever the engine is not idle
//   done                : one-cycle pulse in the finishing cycle
//   err                 : one-cycle pulse after a misaligned start is rejected
//   count               : words written in the current / last copy
//   dbg_state           : current FSM state (IDLE=0, READ=1, WRITE=2, FIN=3)
//   mem                 : memory bus, master side
//
// Handshake: there is no ready on start. A request is taken at a rising edge
// where the engine is idle and start=1; it is answered either by busy rising
// (accepted) or by an err pulse (rejected). While busy=1, start, src_adr,
// dst_adr and len are ignored. On the memory side every cycle with memread or
// memwrite high is a complete transfer; the memory never stalls.
// ----------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int WIDTH   = 32,
  parameter int LENBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   src_adr,
  input  logic [WIDTH-1:0]   dst_adr,
  input  logic [LENBITS-1:0] len,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [LENBITS-1:0] count,
  output logic [1:0]         dbg_state,
  mem_copy_engine_if.master  mem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   src_q, src_d;
  logic [WIDTH-1:0]   dst_q, dst_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [LENBITS-1:0] rem_q, rem_d;
  logic [LENBITS-1:0] count_q, count_d;
  // Registered bus / status outputs, computed from the next state so they
  // are plain flop outputs that still follow the Moore state exactly.
  logic               memread_q, memread_d;
  logic               memwrite_q, memwrite_d;
  logic [WIDTH-1:0]   adr_q, adr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    rem_d   = rem_q;
    count_d = count_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (src_adr[1:0] == 2'b00 && dst_adr[1:0] == 2'b00) begin
            src_d   = src_adr;
            dst_d   = dst_adr;
            rem_d   = len;
            count_d = '0;
            state_d = (len == '0) ? S_FIN : S_READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_READ: begin
        data_d  = mem.memdata;
        src_d   = src_q + WIDTH'(4);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        dst_d   = dst_q + WIDTH'(4);
        count_d = count_q + LENBITS'(1);
        rem_d   = rem_q - LENBITS'(1);
        state_d = (rem_q == LENBITS'(1)) ? S_FIN : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    memread_d  = (state_d == S_READ);
    memwrite_d = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
    // src_d/dst_d already hold the pointer the next cycle will use.
    if (state_d == S_READ) begin
      adr_d = src_d;
    end else if (state_d == S_WRITE) begin
      adr_d = dst_d;
    end else begin
      adr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      adr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      data_q     <= data_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      adr_q      <= adr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign count         = count_q;
  assign dbg_state     = state_q;
  assign mem.memread   = memread_q;
  assign mem.memwrite  = memwrite_q;
  assign mem.adr       = adr_q;
  assign mem.writedata = data_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// ----------------------------------------------------------------------------
// tb_mem_copy_engine
// Scoreboarded bench for mem_copy_engine. A 1 KB memory model (addresses
// alias on bits [9:2]) serves the bus. For each request the reference model
// copies words in an array and pushes the expected read addresses and
// expected {adr,data} writes; a negedge monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_mem_copy_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src_adr;
  logic [31:0] dst_adr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  count;
  logic [1:0]  dbg_state;

  mem_copy_engine_if #(.WIDTH(32)) bus ();

  mem_copy_engine #(.WIDTH(32), .LENBITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_adr   (src_adr),
    .dst_adr   (dst_adr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count),
    .dbg_state (dbg_state),
    .mem       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [0:255];
  logic [31:0] ref_mem [0:255];

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  assign bus.memdata = mem_arr[bus.adr[9:2]];

  always @(posedge clk) begin
    if (bus.memwrite) mem_arr[bus.adr[9:2]] = bus.writedata;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_rd_q [$];
  logic [63:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  logic [7:0] last_count = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.memread && bus.memwrite) chk("rd_wr_exclusive", 64'd1, 64'd0);
      if (bus.memread) begin
        if (exp_rd_q.size() == 0) chk("unexpected_read", {32'd0, bus.adr}, 64'hDEAD);
        else chk("read_adr", {32'd0, bus.adr}, {32'd0, exp_rd_q.pop_front()});
      end
      if (bus.memwrite) begin
        if (exp_q.size() == 0) chk("unexpected_write", {bus.adr, bus.writedata}, 64'hDEAD);
        else chk("write_adr_data", {bus.adr, bus.writedata}, exp_q.pop_front());
      end
      if (!bus.memread && !bus.memwrite) chk("idle_adr", {32'd0, bus.adr}, 64'd0);
      if (done) n_done++;
    end
  end

  // ---------------- reference model ----------------
  // Ascending word-by-word copy: each word is read from the current memory
  // image before it is written, which gives the defined overlap behaviour.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(s + 32'(4 * i));
      v = ref_mem[idx(s + 32'(4 * i))];
      ref_mem[idx(d + 32'(4 * i))] = v;
      exp_q.push_back({d + 32'(4 * i), v});
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mem_arr[idx(a)] = v;
    ref_mem[idx(a)] = v;
  endtask

  // ---------------- driver ----------------
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d,
                         input logic [7:0] n, input bit pulse_again);
    bit aligned;
    int c;
    int done_before;
    aligned = (s[1:0] == 2'b00) && (d[1:0] == 2'b00);
    if (aligned) model_copy(s, d, int'(n));
    done_before = n_done;
    @(negedge clk);
    start = 1'b1; src_adr = s; dst_adr = d; len = n;
    @(posedge clk);
    #1;
    start = 1'b0; src_adr = $urandom; dst_adr = $urandom; len = 8'($urandom);
    if (aligned) begin
      c = 0;
      forever begin
        @(negedge clk);
        chk("busy_during_copy", {63'd0, busy}, 64'd1);
        if (pulse_again && c == 1) begin
          start = 1'b1; src_adr = 32'h10; dst_adr = 32'h20; len = 8'd1;
        end else begin
          start = 1'b0;
        end
        if (done) break;
        c++;
        if (c > 2 * int'(n) + 4) begin
          chk("done_timeout", 64'd0, 64'd1);
          break;
        end
      end
      chk("done_cycle", 64'(c), 64'(2 * int'(n)));
      chk("count_at_done", {56'd0, count}, {56'd0, n});
      last_count = n;
      @(negedge clk);
      chk("busy_after_done", {63'd0, busy}, 64'd0);
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("done_pulses", 64'(n_done - done_before), 64'd1);
    end else begin
      @(negedge clk);
      chk("err_pulse", {63'd0, err}, 64'd1);
      chk("busy_on_err", {63'd0, busy}, 64'd0);
      chk("count_on_err", {56'd0, count}, {56'd0, last_count});
      @(negedge clk);
      chk("err_one_cycle", {63'd0, err}, 64'd0);
    end
  endtask

  task automatic reset_mid_copy();
    logic [31:0] s, d;
    logic [31:0] v;
    s = 32'h140; d = 32'h1C0;
    // Reads of words 0 and 1 happen; only word 0 is written before reset.
    exp_rd_q.push_back(s);
    exp_rd_q.push_back(s + 32'd4);
    v = ref_mem[idx(s)];
    ref_mem[idx(d)] = v;
    exp_q.push_back({d, v});
    @(negedge clk);
    start = 1'b1; src_adr = s; dst_adr = d; len = 8'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_memwrite", {63'd0, bus.memwrite}, 64'd0);
    chk("rst_memread", {63'd0, bus.memread}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_count", {56'd0, count}, 64'd0);
    last_count = 8'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    logic [31:0] s, d;
    logic [7:0]  n;
    int mism;
    reset = 1'b0; start = 1'b0; src_adr = '0; dst_adr = '0; len = '0;
    for (int i = 0; i < 256; i++) poke(32'(i * 4), $urandom);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    chk("reset_count", {56'd0, count}, 64'd0);
    chk("reset_memread", {63'd0, bus.memread}, 64'd0);
    chk("reset_memwrite", {63'd0, bus.memwrite}, 64'd0);
    chk("reset_adr", {32'd0, bus.adr}, 64'd0);
    chk("reset_writedata", {32'd0, bus.writedata}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic copy
    poke(32'h40, 32'd1); poke(32'h44, 32'd2); poke(32'h48, 32'd3);
    do_copy(32'h40, 32'h80, 8'd3, 1'b0);
    chk("basic_word2", {32'd0, mem_arr[idx(32'h88)]}, 64'd3);
    // Zero length
    do_copy(32'h100, 32'h200, 8'd0, 1'b0);
    // Misaligned source / destination
    do_copy(32'h42, 32'h80, 8'd2, 1'b0);
    do_copy(32'h40, 32'h81, 8'd2, 1'b0);
    // Reset mid-copy, then a normal copy
    reset_mid_copy();
    do_copy(32'h140, 32'h240, 8'd2, 1'b0);
    // Start pulsed again while busy
    do_copy(32'h50, 32'h2A0, 8'd3, 1'b1);
    // Overlapping forward copy
    poke(32'h40, 32'd9);
    do_copy(32'h40, 32'h44, 8'd3, 1'b0);
    chk("overlap_4c", {32'd0, mem_arr[idx(32'h4C)]}, 64'd9);
    // Source pointer wrap past all-ones
    do_copy(32'hFFFF_FFFC, 32'h300, 8'd2, 1'b0);

    // Randomized requests
    for (int k = 0; k < 40; k++) begin
      s = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 3) == 0) s[31:10] = 22'($urandom);
      if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
      n = 8'($urandom_range(0, 8));
      do_copy(s, d, n, ($urandom_range(0, 3) == 0) && (n != 8'd0));
    end

    repeat (4) @(negedge clk);
    chk("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    chk("wr_queue_empty", 64'(exp_q.size()), 64'd0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== ref_mem[i]) mism++;
    chk("final_memory_image", 64'(mism), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends with a summary line.
  initial begin
    #2_000_000;
    chk("global_timeout", 64'd0, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
